// File: rtl/par_serializer_pkg.sv
// Shared types for the parallel-to-serial transmit stage.
// Frame phases: load, data bits, parity bit, idle gap.
package par_ser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        GAP
    } par_ser_state_t;

endpackage

// File: rtl/par_serializer.sv
// Parallel-to-serial transmit stage: shifts out a captured word one bit per clock,
// then appends a parity bit and an optional idle gap.
module par_serializer
    import par_ser_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ODD_PARITY = 0,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned MSB_FIRST  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic             din_rdy,
    output logic             sr_out,
    output logic             sr_vld,
    output logic             par_flag,
    output logic             frame_done
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam bit              NO_GAP   = (GAP_CYCLES == 0);
    localparam bit              MSB_SEL  = (MSB_FIRST != 0);

    par_ser_state_t   state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             sr_out_d, sr_vld_d, par_flag_d, frame_done_d;
    logic             gap_last;
    logic             xfer;

    assign din_rdy = (state_q == IDLE) || ((state_q == PAR) && NO_GAP);
    assign xfer    = din_vld && din_rdy;

    // The head bit leaves on the same edge that loads the word, so the shift
    // register only ever holds the bits still to be sent, aligned at the head.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        parity_d     = parity_q;
        bit_cnt_d    = bit_cnt_q;
        sr_out_d     = 1'b0;
        sr_vld_d     = 1'b0;
        par_flag_d   = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: ;
            DATA: begin
                sr_vld_d = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d      = PAR;
                    sr_out_d     = parity_q;
                    par_flag_d   = 1'b1;
                    frame_done_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    sr_out_d  = MSB_SEL ? shreg_q[WIDTH-1] : shreg_q[0];
                    shreg_d   = MSB_SEL ? (shreg_q << 1) : (shreg_q >> 1);
                end
            end
            PAR: begin
                state_d   = NO_GAP ? IDLE : GAP;
                bit_cnt_d = '0;
            end
            GAP: begin
                if (gap_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A transfer (IDLE, or PAR with no gap) starts the next frame without a bubble.
        if (xfer) begin
            state_d   = DATA;
            shreg_d   = MSB_SEL ? (din << 1) : (din >> 1);
            parity_d  = (^din) ^ 1'(ODD_PARITY);
            bit_cnt_d = '0;
            sr_out_d  = MSB_SEL ? din[WIDTH-1] : din[0];
            sr_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            sr_out     <= 1'b0;
            sr_vld     <= 1'b0;
            par_flag   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_out     <= sr_out_d;
            sr_vld     <= sr_vld_d;
            par_flag   <= par_flag_d;
            frame_done <= frame_done_d;
        end
    end

    if (GAP_CYCLES > 0) begin : g_gap
        localparam int unsigned     GAP_W    = $clog2(GAP_CYCLES + 1);
        localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

        logic [GAP_W-1:0] gap_cnt_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                gap_cnt_q <= '0;
            end else if ((state_q == GAP) && !gap_last) begin
                gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end else begin
                gap_cnt_q <= '0;
            end
        end

        assign gap_last = (gap_cnt_q == LAST_GAP);
    end else begin : g_no_gap
        assign gap_last = 1'b1;
    end

endmodule

// File: tb/tb_par_serializer.sv
// Directed bench for par_serializer: four parameterisations share clock and reset,
// a vector table covers whole frames, hand sequences cover back-to-back, busy and reset.
module tb_par_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din_a [4];
    logic [3:0] vld_v;
    logic [3:0] rdy_v, sro_v, srv_v, pf_v, fd_v;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // 0: even/gap1/lsb  1: odd/gap1/lsb  2: even/gap0/lsb  3: even/gap1/msb
    par_serializer #(.WIDTH(8), .ODD_PARITY(0), .GAP_CYCLES(1), .MSB_FIRST(0)) dut_even (
        .clk(clk), .rst(rst), .din(din_a[0]), .din_vld(vld_v[0]), .din_rdy(rdy_v[0]),
        .sr_out(sro_v[0]), .sr_vld(srv_v[0]), .par_flag(pf_v[0]), .frame_done(fd_v[0])
    );
    par_serializer #(.WIDTH(8), .ODD_PARITY(1), .GAP_CYCLES(1), .MSB_FIRST(0)) dut_odd (
        .clk(clk), .rst(rst), .din(din_a[1]), .din_vld(vld_v[1]), .din_rdy(rdy_v[1]),
        .sr_out(sro_v[1]), .sr_vld(srv_v[1]), .par_flag(pf_v[1]), .frame_done(fd_v[1])
    );
    par_serializer #(.WIDTH(8), .ODD_PARITY(0), .GAP_CYCLES(0), .MSB_FIRST(0)) dut_b2b (
        .clk(clk), .rst(rst), .din(din_a[2]), .din_vld(vld_v[2]), .din_rdy(rdy_v[2]),
        .sr_out(sro_v[2]), .sr_vld(srv_v[2]), .par_flag(pf_v[2]), .frame_done(fd_v[2])
    );
    par_serializer #(.WIDTH(8), .ODD_PARITY(0), .GAP_CYCLES(1), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .din(din_a[3]), .din_vld(vld_v[3]), .din_rdy(rdy_v[3]),
        .sr_out(sro_v[3]), .sr_vld(srv_v[3]), .par_flag(pf_v[3]), .frame_done(fd_v[3])
    );

    // exp[k] is the k-th bit on sr_out; exp[8] is the parity bit.
    typedef struct {
        int         sel;
        logic [7:0] din;
        logic [8:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int sel);
        int n = 0;
        while (!(rdy_v[sel] === 1'b1 && srv_v[sel] === 1'b0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_frame", 32'(rdy_v[sel]), 32'd1);
    endtask

    // Entered on the negedge showing data bit 0; leaves on the parity-bit negedge.
    task automatic collect(input int sel, output logic [8:0] bits, output logic ok);
        ok = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k != 0) @(negedge clk);
            bits[k] = sro_v[sel];
            if (srv_v[sel] !== 1'b1 || pf_v[sel] !== (k == 8) || fd_v[sel] !== (k == 8)) begin
                ok = 1'b0;
            end
        end
    endtask

    task automatic run_vec(input int i);
        logic [8:0] bits;
        logic       ok;
        int         sel = vecs[i].sel;
        wait_ready(sel);
        @(negedge clk);
        din_a[sel] = vecs[i].din;
        vld_v[sel] = 1'b1;
        @(negedge clk);
        vld_v[sel] = 1'b0;
        din_a[sel] = ~vecs[i].din;
        collect(sel, bits, ok);
        check({vecs[i].name, "_bits"}, 32'(bits), 32'(vecs[i].exp));
        check({vecs[i].name, "_flags"}, 32'(ok), 32'd1);
        // Loop-back parity detector: data+parity popcount matches the configured parity.
        check({vecs[i].name, "_loopback"}, 32'((^bits) ^ (sel == 1)), 32'd0);
        @(negedge clk);
        check({vecs[i].name, "_after_vld"}, 32'(srv_v[sel]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0]  bits;
        logic        ok;
        logic [17:0] v18, b18, r18;
        int          hits;

        vecs[0] = '{0, 8'hA5, 9'b0_1010_0101, "a5_even"};
        vecs[1] = '{1, 8'h01, 9'b0_0000_0001, "01_odd"};
        vecs[2] = '{0, 8'h01, 9'b1_0000_0001, "01_even"};
        vecs[3] = '{3, 8'hC0, 9'b0_0000_0011, "c0_msb"};
        vecs[4] = '{0, 8'h7F, 9'b1_0111_1111, "7f_even"};
        vecs[5] = '{3, 8'h35, 9'b0_1010_1100, "35_msb"};
        vecs[6] = '{1, 8'hE7, 9'b1_1110_0111, "e7_odd"};
        vecs[7] = '{0, 8'h81, 9'b0_1000_0001, "81_after_rst"};

        vld_v = '0;
        for (int s = 0; s < 4; s++) din_a[s] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({sro_v, srv_v, pf_v, fd_v}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_outputs", 32'({sro_v, srv_v, pf_v, fd_v}), 32'd0);
        check("post_rst_rdy", 32'(rdy_v), 32'hF);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Back-to-back with no gap: FF then 00 with din_vld held high.
        wait_ready(2);
        @(negedge clk);
        din_a[2] = 8'hFF;
        vld_v[2] = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 0) din_a[2] = 8'h00;
            if (i == 9) vld_v[2] = 1'b0;
            v18[i] = srv_v[2];
            b18[i] = sro_v[2];
            r18[i] = rdy_v[2];
        end
        check("b2b_vld_run", 32'(v18), 32'h3FFFF);
        check("b2b_bits", 32'(b18), 32'h000FF);
        check("b2b_rdy", 32'(r18), 32'h20100);
        @(negedge clk);
        check("b2b_end_idle", 32'({srv_v[2], rdy_v[2]}), 32'b01);

        // Word offered during DATA is ignored until IDLE returns.
        wait_ready(0);
        @(negedge clk);
        din_a[0] = 8'h7F;
        vld_v[0] = 1'b1;
        @(negedge clk);
        din_a[0] = 8'h3C;
        collect(0, bits, ok);
        check("busy_frame_bits", 32'(bits), 32'(9'b1_0111_1111));
        check("busy_frame_flags", 32'(ok), 32'd1);
        @(negedge clk);
        check("busy_gap_rdy", 32'({srv_v[0], rdy_v[0]}), 32'b00);
        @(negedge clk);
        check("busy_idle_rdy", 32'(rdy_v[0]), 32'd1);
        @(negedge clk);
        vld_v[0] = 1'b0;
        collect(0, bits, ok);
        check("3c_bits", 32'(bits), 32'(9'b0_0011_1100));
        check("3c_flags", 32'(ok), 32'd1);

        // Reset pulsed while bit 4 of A5 is on the line.
        wait_ready(0);
        @(negedge clk);
        din_a[0] = 8'hA5;
        vld_v[0] = 1'b1;
        @(negedge clk);
        vld_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_bit4", 32'({srv_v[0], pf_v[0], sro_v[0]}), 32'b100);
        #2 rst = 1'b1;
        #1 check("rst_async_clear", 32'({sro_v[0], srv_v[0], pf_v[0], fd_v[0]}), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_release_rdy", 32'(rdy_v[0]), 32'd1);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (srv_v[0] !== 1'b0 || fd_v[0] !== 1'b0) hits++;
        end
        check("rst_no_tail", 32'(hits), 32'd0);
        run_vec(7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
